// File: rtl/mul_border_pkg.sv
// Shared constants and operand helpers for the border multiplier.
// Operands are sign-magnitude: the top bit is the sign, the rest the magnitude.
// The helpers take a wide container plus the real operand width, so that
// modules with different WIDTH parameters can all use them.
package mul_border_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int LANES_DEF = 4;
    localparam int MAX_W     = 64;

    // Magnitude field of a sign-magnitude operand of the given width.
    function automatic logic [MAX_W-1:0] mag_of(input logic [MAX_W-1:0] v, input int width);
        return v & ((MAX_W'(1) << (width - 1)) - MAX_W'(1));
    endfunction

    // Sign bit of a sign-magnitude operand of the given width.
    function automatic logic sign_of(input logic [MAX_W-1:0] v, input int width);
        return v[width-1];
    endfunction

    // Low bit index of a lane inside a packed multi-lane bus.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mul_border_mc_if.sv
// Control and data bundle of the border multiplier.
//   init, clr          : operation start / abort strobes
//   i_data_i, i_data_w : packed per-lane sign-magnitude operands
//   o_bit, o_sign      : per-lane product bit stream and product sign
//   o_busy, o_done     : per-lane activity and the shared completion pulse
// master drives the strobes and operands; slave is the multiplier itself.
interface mul_border_mc_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 4
);
    logic                   init;
    logic                   clr;
    logic [LANES*WIDTH-1:0] i_data_i;
    logic [LANES*WIDTH-1:0] i_data_w;
    logic [LANES-1:0]       o_bit;
    logic [LANES-1:0]       o_sign;
    logic [LANES-1:0]       o_busy;
    logic                   o_done;

    modport master (
        output init, clr, i_data_i, i_data_w,
        input  o_bit, o_sign, o_busy, o_done
    );

    modport slave (
        input  init, clr, i_data_i, i_data_w,
        output o_bit, o_sign, o_busy, o_done
    );
endinterface

// File: rtl/mul_border_mc_vdc_rng.sv
// Van der Corput (first Sobol dimension) sequence generator.
// An MAG-bit up-counter whose bit-reversed value is the random number.
//   clk, rst : clock, synchronous active-high reset
//   restart  : return the sequence to its first value (0)
//   enable   : advance one step
//   o_rnd    : current sequence value
module vdc_rng #(
    parameter int MAG = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           restart,
    input  logic           enable,
    output logic [MAG-1:0] o_rnd
);
    logic [MAG-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (restart)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + MAG'(1);
    end

    always_comb begin
        o_rnd = '0;
        for (int b = 0; b < MAG; b++)
            o_rnd[b] = cnt[MAG-1-b];
    end
endmodule

// File: rtl/mul_border_mc.sv
// Multi-lane border processing element of the unary-temporal systolic array.
// Each lane counts its input magnitude down as a temporal pulse train and
// gates every pulse with (latched weight > low-discrepancy sample), so the
// number of ones approximates mag_i*mag_w/2^MAG. The product sign is latched
// at init. A shared arm flag raises o_done for one cycle once every lane of
// an operation has finished.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mul_border_mc_if (init/clr, operands, results)
module mul_border_mc
    import mul_border_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mul_border_mc_if.slave     bus
);
    localparam int MAG = WIDTH - 1;

    logic [LANES-1:0] busy;
    logic             arm;
    logic             done;

    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [WIDTH-1:0] op_i;
            logic [WIDTH-1:0] op_w;
            logic [MAG-1:0]   mag_i;
            logic [MAG-1:0]   mag_w;
            logic             sgn;
            logic [MAG-1:0]   cnt;
            logic [MAG-1:0]   wreg;
            logic             sreg;
            logic [MAG-1:0]   rnd;

            assign op_i  = bus.i_data_i[lane_lo(l, WIDTH) +: WIDTH];
            assign op_w  = bus.i_data_w[lane_lo(l, WIDTH) +: WIDTH];
            assign mag_i = MAG'(mag_of(MAX_W'(op_i), WIDTH));
            assign mag_w = MAG'(mag_of(MAX_W'(op_w), WIDTH));
            assign sgn   = sign_of(MAX_W'(op_i), WIDTH) ^ sign_of(MAX_W'(op_w), WIDTH);

            // Weight and sign are captured only at init; the ports are
            // ignored for the rest of the operation.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt  <= '0;
                    wreg <= '0;
                    sreg <= 1'b0;
                end else if (bus.init) begin
                    cnt  <= mag_i;
                    wreg <= mag_w;
                    sreg <= sgn;
                end else if (bus.clr) begin
                    cnt  <= '0;
                end else if (cnt != '0) begin
                    cnt  <= cnt - MAG'(1);
                end
            end

            // The sequence only moves while this lane emits pulses, so each
            // train sees 0, 2^(MAG-1), 2^(MAG-2), ... from its first cycle.
            vdc_rng #(.MAG(MAG)) u_rng (
                .clk     (clk),
                .rst     (rst),
                .restart (bus.init),
                .enable  (busy[l] & ~bus.clr),
                .o_rnd   (rnd)
            );

            assign busy[l]       = (cnt != '0);
            assign bus.o_bit[l]  = busy[l] & (wreg > rnd);
            assign bus.o_sign[l] = sreg;
        end
    endgenerate

    assign done       = arm & ~(|busy);
    assign bus.o_busy = busy;
    assign bus.o_done = done;

    // arm marks an operation whose completion has not been reported yet;
    // it drops on the edge closing the o_done cycle, giving a 1-cycle pulse.
    always_ff @(posedge clk) begin
        if (rst)
            arm <= 1'b0;
        else if (bus.init)
            arm <= 1'b1;
        else if (bus.clr)
            arm <= 1'b0;
        else if (done)
            arm <= 1'b0;
    end
endmodule

// File: tb/tb_mul_border_mc.sv
module tb_mul_border_mc;
    localparam int WIDTH = 16;
    localparam int LANES = 4;
    localparam int MAG   = WIDTH - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_border_mc_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    mul_border_mc #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: each lane remembers its train length, its weight,
    // its sign and how many pulses it has emitted since the last init.
    // Pulse k of a train uses the k-th van der Corput sample.
    // ------------------------------------------------------------------
    int m_len [LANES];
    int m_k   [LANES];
    int m_w   [LANES];
    bit m_sign[LANES];
    bit m_armed;
    bit cmp_en = 1'b0;

    function automatic int vdc(input int k);
        int r;
        int v;
        r = 0;
        v = k % (1 << MAG);
        for (int b = 0; b < MAG; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    initial begin
        m_armed = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            m_len[l] = 0; m_k[l] = 0; m_w[l] = 0; m_sign[l] = 1'b0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                m_armed = 1'b0;
                for (int l = 0; l < LANES; l++) begin
                    m_len[l] = 0; m_k[l] = 0; m_w[l] = 0; m_sign[l] = 1'b0;
                end
            end else if (bus.init) begin
                m_armed = 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    m_len[l]  = int'(bus.i_data_i[l*WIDTH +: MAG]);
                    m_w[l]    = int'(bus.i_data_w[l*WIDTH +: MAG]);
                    m_sign[l] = bus.i_data_i[l*WIDTH+WIDTH-1] ^ bus.i_data_w[l*WIDTH+WIDTH-1];
                    m_k[l]    = 0;
                end
            end else if (bus.clr) begin
                m_armed = 1'b0;
                for (int l = 0; l < LANES; l++) m_len[l] = 0;
            end else begin
                bit any;
                any = 1'b0;
                for (int l = 0; l < LANES; l++) if (m_k[l] < m_len[l]) any = 1'b1;
                if (m_armed && !any) m_armed = 1'b0;
                for (int l = 0; l < LANES; l++) if (m_k[l] < m_len[l]) m_k[l]++;
            end
        end
    end

    logic [LANES-1:0] e_busy, e_bit, e_sign;
    logic             e_done;

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                e_busy = '0; e_bit = '0; e_sign = '0;
                for (int l = 0; l < LANES; l++) begin
                    e_busy[l] = (m_k[l] < m_len[l]);
                    e_bit[l]  = e_busy[l] && (m_w[l] > vdc(m_k[l]));
                    e_sign[l] = m_sign[l];
                end
                e_done = m_armed && (e_busy == '0);
                check("model_busy", bus.o_busy, e_busy);
                check("model_bit",  bus.o_bit,  e_bit);
                check("model_sign", bus.o_sign, e_sign);
                check("model_done", bus.o_done, e_done);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic set_lane(input int l, input logic [WIDTH-1:0] i, input logic [WIDTH-1:0] w);
        bus.i_data_i[l*WIDTH +: WIDTH] = i;
        bus.i_data_w[l*WIDTH +: WIDTH] = w;
    endtask

    task automatic clear_ops();
        bus.i_data_i = '0;
        bus.i_data_w = '0;
    endtask

    // Called just after a falling edge; returns in the first cycle after init.
    task automatic pulse_init();
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
    endtask

    logic [LANES-1:0] t2_busy [6] = '{4'b1011, 4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0000};
    logic [LANES-1:0] t2_bit  [6] = '{4'b1001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    int ones;
    int dones;

    initial begin
        rst = 1'b1;
        bus.init = 1'b0;
        bus.clr  = 1'b0;
        clear_ops();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        check("rst_bit",  bus.o_bit,  '0);
        check("rst_sign", bus.o_sign, '0);
        check("rst_busy", bus.o_busy, '0);
        check("rst_done", bus.o_done, '0);
        @(negedge clk);

        // 1: single-lane train
        clear_ops();
        set_lane(0, 16'd8, 16'd16384);
        pulse_init();
        for (int k = 0; k < 8; k++) begin
            check("t1_bit",  bus.o_bit[0], (k % 2 == 0) ? 1 : 0);
            check("t1_busy", bus.o_busy[0], 1);
            check("t1_done_early", bus.o_done, 0);
            @(negedge clk);
        end
        check("t1_busy_end", bus.o_busy, 0);
        check("t1_done", bus.o_done, 1);
        @(negedge clk);
        check("t1_done_once", bus.o_done, 0);

        // 2: signs and independent train lengths
        clear_ops();
        set_lane(0, 16'h8003, 16'h7FFF);
        set_lane(1, 16'h0005, 16'h8000);
        set_lane(2, 16'h0000, 16'h0064);
        set_lane(3, 16'h8001, 16'h8001);
        pulse_init();
        check("t2_sign", bus.o_sign, 4'b0011);
        for (int k = 0; k < 6; k++) begin
            check("t2_busy", bus.o_busy, t2_busy[k]);
            check("t2_bit",  bus.o_bit,  t2_bit[k]);
            check("t2_done", bus.o_done, (k == 5) ? 1 : 0);
            @(negedge clk);
        end
        check("t2_done_once", bus.o_done, 0);

        // 3: clr abort, then rng restart on the next init
        clear_ops();
        set_lane(0, 16'd20, 16'd16384);
        pulse_init();
        repeat (5) @(negedge clk);
        check("t3_busy_before_clr", bus.o_busy[0], 1);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check("t3_busy_after_clr", bus.o_busy, 0);
        for (int k = 0; k < 5; k++) begin
            check("t3_no_done", bus.o_done, 0);
            @(negedge clk);
        end
        set_lane(0, 16'd4, 16'd1);
        pulse_init();
        check("t3_first_bit", bus.o_bit[0], 1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("t3_later_bit", bus.o_bit[0], 0);
        end
        @(negedge clk);
        check("t3_done", bus.o_done, 1);
        @(negedge clk);

        // 4: re-init mid-run together with clr
        clear_ops();
        set_lane(0, 16'd10, 16'd16384);
        dones = 0;
        pulse_init();
        repeat (3) begin
            dones += int'(bus.o_done);
            @(negedge clk);
        end
        dones += int'(bus.o_done);
        set_lane(0, 16'd3, 16'd16384);
        bus.clr = 1'b1;
        pulse_init();
        bus.clr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k < 3) check("t4_bit", bus.o_bit[0], (k % 2 == 0) ? 1 : 0);
            check("t4_done_at", bus.o_done, (k == 3) ? 1 : 0);
            dones += int'(bus.o_done);
            @(negedge clk);
        end
        check("t4_done_count", dones, 1);

        // 5: zero operation, then reset mid-run
        clear_ops();
        pulse_init();
        check("t5_zero_done", bus.o_done, 1);
        check("t5_zero_bit",  bus.o_bit, 0);
        @(negedge clk);
        check("t5_zero_done_once", bus.o_done, 0);
        set_lane(0, 16'd100, 16'hC000);
        pulse_init();
        check("t5_run_sign", bus.o_sign[0], 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t5_rst_bit",  bus.o_bit,  0);
            check("t5_rst_busy", bus.o_busy, 0);
            check("t5_rst_sign", bus.o_sign, 0);
            check("t5_rst_done", bus.o_done, 0);
            @(negedge clk);
        end

        // 6: weight latched at init
        clear_ops();
        set_lane(0, 16'd16, 16'd16384);
        pulse_init();
        bus.i_data_w = '0;
        ones = 0;
        for (int k = 0; k < 16; k++) begin
            check("t6_bit", bus.o_bit[0], (k % 2 == 0) ? 1 : 0);
            ones += int'(bus.o_bit[0]);
            @(negedge clk);
        end
        check("t6_ones", ones, 8);
        check("t6_done", bus.o_done, 1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
